// File: rtl/cnn16_ram_loader.sv
// Byte-stream to 16-bit RAM loader: packs byte pairs (high byte first) into words,
// writes them to consecutive addresses from a base and keeps an additive checksum.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; outputs hold their last values
// HI    | accepting the high byte of the next word
// LO    | accepting the low byte; on handshake the write is staged
// WRITE | mem_write high for this single cycle, checksum/counters advance
// DONE  | one-cycle done pulse, then back to IDLE
module cnn16_ram_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        LO    = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [7:0]            hi_byte;
    logic                  handshake;

    assign handshake = byte_valid && byte_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            remaining   <= '0;
            hi_byte     <= '0;
            byte_ready  <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            checksum    <= '0;
        end else begin
            mem_write <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= word_count;
                        checksum  <= '0;
                        if (word_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= HI;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (handshake) begin
                        hi_byte <= byte_data;
                        state   <= LO;
                    end
                end
                LO: begin
                    // The write is staged here so mem_* are registered for the WRITE cycle.
                    if (handshake) begin
                        mem_data_in <= DATA_WIDTH'({hi_byte, byte_data});
                        mem_address <= addr;
                        mem_write   <= 1'b1;
                        byte_ready  <= 1'b0;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    checksum  <= checksum + mem_data_in;
                    addr      <= addr + ADDR_WIDTH'(1);
                    remaining <= remaining - (ADDR_WIDTH+1)'(1);
                    if (remaining == (ADDR_WIDTH+1)'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state      <= HI;
                        byte_ready <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn16_ram_loader.sv
// Randomized bench for cnn16_ram_loader: a RAM array captures writes and every load
// is compared with a list of expected (address, word) pairs and checksum built from the bytes sent.
module tb_cnn16_ram_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_write;
    logic [11:0] mem_address;
    logic [15:0] mem_data_in;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    cnn16_ram_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_data_in(mem_data_in),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // RAM and write monitor
    logic [15:0] ram [0:4095];
    int          cap_addr[$];
    int          cap_data[$];
    int          done_cnt;
    int          bad_ready;
    int          double_wr;
    logic        prev_wr = 1'b0;
    logic [7:0]  src[$];

    always @(posedge clk) begin
        if (mem_write) begin
            ram[mem_address] = mem_data_in;
            cap_addr.push_back(int'(mem_address));
            cap_data.push_back(int'(mem_data_in));
            if (byte_ready) bad_ready++;
            if (prev_wr) double_wr++;
        end
        prev_wr = mem_write;
        if (done) done_cnt++;
    end

    task automatic clear_monitor();
        cap_addr.delete();
        cap_data.delete();
        done_cnt  = 0;
        bad_ready = 0;
        double_wr = 0;
    endtask

    // Sends src[0 .. nbytes-1]; inputs change on the falling edge, byte_ready is stable there.
    task automatic feed(input string tag, input int nbytes, input int gap_pct, input bit extra);
        int idx   = 0;
        int guard = 0;
        bit hs;
        while (idx < nbytes && guard < nbytes * 10 + 100) begin
            byte_valid = ($urandom_range(99) >= gap_pct);
            byte_data  = byte_valid ? src[idx] : 8'($urandom);
            if (extra) begin
                start      = ($urandom_range(3) == 0);
                base_addr  = 12'($urandom);
                word_count = 13'($urandom);
            end
            hs = byte_valid && byte_ready;
            @(negedge clk);
            if (hs) idx++;
            guard++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        check({tag, "_feed_timeout"}, idx, nbytes);
    endtask

    task automatic do_load(input string tag, input logic [11:0] base, input int n,
                           input int gap_pct, input bit extra);
        logic [15:0] exp_ck = '0;
        logic [15:0] w;
        int          tmo = 0;
        clear_monitor();
        @(negedge clk);
        start      = 1'b1;
        base_addr  = base;
        word_count = 13'(n);
        @(negedge clk);
        start      = 1'b0;
        base_addr  = 12'($urandom);
        word_count = 13'($urandom);
        if (n == 0) begin
            check({tag, "_done_early"}, done, 1'b1);
            check({tag, "_busy_early"}, busy, 1'b0);
        end else begin
            check({tag, "_busy_early"}, busy, 1'b1);
            feed(tag, 2 * n, gap_pct, extra);
        end
        while (done_cnt == 0 && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        check({tag, "_done_timeout"}, (done_cnt > 0), 1'b1);
        repeat (2) @(negedge clk);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_low"}, done, 1'b0);
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_nwrites"}, cap_addr.size(), n);
        for (int i = 0; i < n; i++) begin
            w = {src[2*i], src[2*i+1]};
            exp_ck = exp_ck + w;
            if (i < cap_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), cap_addr[i], (int'(base) + i) % 4096);
                check($sformatf("%s_data%0d", tag, i), cap_data[i], int'(w));
            end
        end
        check({tag, "_checksum"}, checksum, exp_ck);
        check({tag, "_ready_in_write"}, bad_ready, 0);
        check({tag, "_double_write"}, double_wr, 0);
    endtask

    task automatic rand_src(input int nbytes);
        src.delete();
        for (int i = 0; i < nbytes; i++) src.push_back(8'($urandom));
    endtask

    logic [11:0] b;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_byte_ready", byte_ready, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_checksum", checksum, 16'h0);
        check("rst_mem_address", mem_address, 12'h0);
        check("rst_mem_data_in", mem_data_in, 16'h0);

        src = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        do_load("t2", 12'h010, 2, 0, 1'b0);
        check("t2_ck_const", checksum, 16'hBE01);
        check("t2_ram10", ram[12'h010], 16'h1234);
        check("t2_ram11", ram[12'h011], 16'hABCD);

        src = '{8'h00, 8'h01, 8'h00, 8'h02};
        do_load("t3", 12'hFFF, 2, 0, 1'b0);
        check("t3_ramfff", ram[12'hFFF], 16'h0001);
        check("t3_ram000", ram[12'h000], 16'h0002);

        do_load("t4", 12'($urandom), 0, 0, 1'b0);
        check("t4_ck_zero", checksum, 16'h0);

        rand_src(32);
        b = 12'($urandom);
        do_load("t5_nogap", b, 16, 0, 1'b0);
        do_load("t5_gap", b, 16, 50, 1'b1);
        for (int i = 0; i < 16; i++)
            check($sformatf("t5_ram%0d", i), ram[12'(int'(b) + i)], {src[2*i], src[2*i+1]});

        // reset while the high byte of the third word is held
        rand_src(10);
        b = 12'($urandom);
        clear_monitor();
        @(negedge clk);
        start = 1'b1; base_addr = b; word_count = 13'd5;
        @(negedge clk);
        start = 1'b0;
        feed("t6", 5, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", busy, 1'b0);
        check("t6_ready", byte_ready, 1'b0);
        check("t6_mem_write", mem_write, 1'b0);
        check("t6_nwrites", cap_addr.size(), 2);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t6_ram%0d", i), ram[12'(int'(b) + i)], {src[2*i], src[2*i+1]});
        end
        rand_src(10);
        do_load("t6_after", 12'($urandom), 5, 20, 1'b0);

        for (int k = 0; k < 4; k++) begin
            int n = $urandom_range(20, 1);
            rand_src(2 * n);
            do_load($sformatf("rnd%0d", k), 12'($urandom), n, $urandom_range(60), 1'b1);
        end

        rand_src(8192);
        do_load("full", 12'($urandom_range(4095, 1)), 4096, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
